pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- PC register, next-PC selection and instruction fetch sequencing for the single-cycle MIPS core with jr support.
- Sits downstream of the immediate extender: it consumes the sign-extended offset (EXTop=10 output) as the branch displacement.
- Sits upstream of decode: it presents the fetched instruction word, from which imm16 and EXTop are derived.
- Uses a two-phase FETCH/EXEC handshake against instruction memory, so slow memories are tolerated.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset (first fetch address).
- ADDR_W, 32, PC/address width; fixed at 32 in this core.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- npc_op  in  3  next-PC select from controller: 000 seq, 001 beq, 010 bne, 011 j, 100 jal, 101 jr, 11x treated as seq
- zero  in  1  ALU zero flag, valid in EXEC
- ext_imm  in  32  sign-extended imm16 from extender
- instr_index  in  26  instr[25:0], j/jal target field
- jr_target  in  32  rs register value for jr
- stall  in  1  hold EXEC (no PC update) while high
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address (= pc)
- imem_ready  in  1  memory has valid data this cycle
- imem_rdata  in  32  fetched instruction word
- instr  out  32  instruction register
- instr_valid  out  1  high in EXEC; the core executes instr
- pc  out  32  current PC
- pc_plus4  out  32  pc+4, used as jal link value
- pc_err  out  1  one-cycle pulse on misaligned jr target

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, pc_err=0, state=BOOT.
  - Reset mid-fetch abandons the request immediately; a late imem_ready is ignored.
- States: BOOT -> FETCH -> EXEC -> FETCH ...
  - BOOT: a single cycle after reset release; imem_req=0; unconditional transition to FETCH.
  - FETCH: imem_req=1 and imem_addr=pc, held stable until imem_ready.
    - On a rising edge with imem_ready=1: instr<=imem_rdata, go to EXEC.
    - Otherwise remain in FETCH; instr is unchanged.
  - EXEC: instr_valid=1, imem_req=0.
    - If stall=1: remain in EXEC; pc, instr and pc_plus4 are unchanged.
    - Else: pc<=npc, go to FETCH.
- Minimum throughput: 2 cycles per instruction (ready already high in the FETCH cycle).
- pc_plus4 = pc+4 (combinational), modulo 2^32.
- npc rules, all arithmetic 32-bit with wrap-around and carry discarded:
  - seq: pc+4
  - beq: zero ? pc+4+(ext_imm<<2) : pc+4
  - bne: !zero ? pc+4+(ext_imm<<2) : pc+4
  - j/jal: {pc_plus4[31:28], instr_index, 2'b00}
  - jr: {jr_target[31:2], 2'b00}. If jr_target[1:0]!=0, pc_err=1 for exactly the committing EXEC->FETCH edge's following cycle; the aligned target is still used.
- npc_op, zero, ext_imm, instr_index and jr_target are sampled only at the EXEC commit edge; their values in FETCH/BOOT are don't-care.
- imem_ready outside FETCH is ignored.
- pc_err is 0 except for the single pulse cycle.
- No output changes combinationally from imem_rdata.

Decomposition:
- Package pc_fetch_pkg:
  - NPC_SEQ/BEQ/BNE/J/JAL/JR 3-bit constants
  - state encoding BOOT/FETCH/EXEC (2-bit)
  - default RESET_PC
- Sub-module npc_calc: purely combinational next-PC and misalign flag from (pc, npc_op, zero, ext_imm, instr_index, jr_target).
- pc_fetch_unit holds the FSM, PC, IR and pc_err registers.

Test Plan:
- Reset then imem_ready tied 1, npc_op=000:
  - imem_addr sequence 0x3000, 0x3004, 0x3008.
  - imem_req high only in FETCH.
  - 2 cycles per instruction.
- beq with zero=1, ext_imm=0xFFFF_FFFF at pc=0x3008: next fetch at 0x3008.
- beq with zero=0, ext_imm=0xFFFF_FFFF at pc=0x3008: next fetch at 0x300C.
- bne with zero=0, ext_imm=0x0000_0004 at pc=0x3000: next 0x3014.
- jal with pc=0x3010, instr_index=0x0000C40: pc_plus4=0x3014 during EXEC; next pc=0x0000_3100.
- jr with jr_target=0x0000_3023:
  - next pc=0x3020.
  - pc_err pulses exactly one cycle.
  - jr_target=0x3020 gives no pulse.
- imem_ready low for 3 cycles in FETCH:
  - imem_addr stable and instr unchanged.
  - capture on the 4th cycle.
  - stall=1 for 2 EXEC cycles holds pc.
  - rst_n low mid-FETCH forces pc=0x3000 and imem_req=0 asynchronously.

Source files
------------

// File: rtl/pc_fetch_pkg.sv
// Shared constants for the fetch unit: next-PC select codes, FSM states, reset vector.
package pc_fetch_pkg;

    localparam logic [2:0] NPC_SEQ = 3'b000;
    localparam logic [2:0] NPC_BEQ = 3'b001;
    localparam logic [2:0] NPC_BNE = 3'b010;
    localparam logic [2:0] NPC_J   = 3'b011;
    localparam logic [2:0] NPC_JAL = 3'b100;
    localparam logic [2:0] NPC_JR  = 3'b101;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'b00,
        ST_FETCH = 2'b01,
        ST_EXEC  = 2'b10
    } state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

endpackage

// File: rtl/npc_calc.sv
// Combinational next-PC selection and jr misalignment detection.
module npc_calc
    import pc_fetch_pkg::*;
(
    input  logic [31:0] i_pc,
    input  logic [2:0]  i_npc_op,
    input  logic        i_zero,
    input  logic [31:0] i_ext_imm,
    input  logic [25:0] i_instr_index,
    input  logic [31:0] i_jr_target,
    output logic [31:0] o_pc_plus4,
    output logic [31:0] o_npc,
    output logic        o_misalign
);

    logic [31:0] w_branch_target;
    logic [31:0] w_jump_target;

    assign o_pc_plus4      = i_pc + 32'd4;
    assign w_branch_target = o_pc_plus4 + {i_ext_imm[29:0], 2'b00};
    assign w_jump_target   = {o_pc_plus4[31:28], i_instr_index, 2'b00};

    always_comb begin
        // NOTE: defaults first so no path through the case leaves an output unassigned (no latch).
        o_npc      = o_pc_plus4;
        o_misalign = 1'b0;
        case (i_npc_op)
            NPC_BEQ: if (i_zero)  o_npc = w_branch_target;
            NPC_BNE: if (!i_zero) o_npc = w_branch_target;
            NPC_J,
            NPC_JAL: o_npc = w_jump_target;
            NPC_JR: begin
                o_npc      = {i_jr_target[31:2], 2'b00};
                o_misalign = |i_jr_target[1:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register, instruction register and BOOT/FETCH/EXEC sequencing against instruction memory.
module pc_fetch_unit
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        npc_op,
    input  logic              zero,
    input  logic [31:0]       ext_imm,
    input  logic [25:0]       instr_index,
    input  logic [ADDR_W-1:0] jr_target,
    input  logic              stall,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instr,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              pc_err
);

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic        r_pc_err;
    logic [31:0] w_npc;
    logic        w_misalign;
    logic        w_capture;
    logic        w_commit;

    npc_calc u_npc_calc (
        .i_pc          (r_pc),
        .i_npc_op      (npc_op),
        .i_zero        (zero),
        .i_ext_imm     (ext_imm),
        .i_instr_index (instr_index),
        .i_jr_target   (jr_target),
        .o_pc_plus4    (pc_plus4),
        .o_npc         (w_npc),
        .o_misalign    (w_misalign)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking so every register samples pre-edge values regardless of statement order.
        if (!rst_n) r_state <= ST_BOOT;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        imem_req     = 1'b0;
        instr_valid  = 1'b0;
        w_capture    = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            ST_BOOT: w_next_state = ST_FETCH;
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    w_capture    = 1'b1;
                    w_next_state = ST_EXEC;
                end
            end
            ST_EXEC: begin
                instr_valid = 1'b1;
                if (!stall) begin
                    w_commit     = 1'b1;
                    w_next_state = ST_FETCH;
                end
            end
            default: w_next_state = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc     <= RESET_PC;
            r_instr  <= 32'h0;
            r_pc_err <= 1'b0;
        end else begin
            if (w_capture) r_instr <= imem_rdata;
            if (w_commit)  r_pc    <= w_npc;
            // Pulse lasts only the cycle after a committing jr to a misaligned target.
            r_pc_err <= w_commit && (npc_op == NPC_JR) && w_misalign;
        end
    end

    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign instr     = r_instr;
    assign pc_err    = r_pc_err;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench: directed vector table, random instruction stream vs. arithmetic model, reset corners.
module tb_pc_fetch_unit;
    import pc_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  npc_op = 3'b000;
    logic        zero = 1'b0;
    logic [31:0] ext_imm = 32'h0;
    logic [25:0] instr_index = 26'h0;
    logic [31:0] jr_target = 32'h0;
    logic        stall = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        pc_err;

    always #5 clk = ~clk;

    pc_fetch_unit #(.RESET_PC(32'h0000_3000), .ADDR_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .npc_op      (npc_op),
        .zero        (zero),
        .ext_imm     (ext_imm),
        .instr_index (instr_index),
        .jr_target   (jr_target),
        .stall       (stall),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .pc_err      (pc_err)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] m_pc;
    logic [31:0] m_instr;

    typedef struct {
        logic [2:0]  op;
        logic        z;
        logic [31:0] ext;
        logic [25:0] idx;
        logic [31:0] jr;
        int          delay;
        int          stalls;
        logic [31:0] exp_pc;
        logic [31:0] exp_npc;
        logic        exp_err;
    } vec_t;

    vec_t vt[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b expected=%b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference next-PC from the architectural rules, plain 32-bit arithmetic.
    function automatic logic [31:0] model_npc(input logic [31:0] p, input logic [2:0] op,
                                              input logic z, input logic [31:0] e,
                                              input logic [25:0] idx, input logic [31:0] jr);
        logic [31:0] p4;
        logic [31:0] tgt;
        p4  = p + 32'd4;
        tgt = p4 + e * 32'd4;
        case (op)
            3'd1:    return z ? tgt : p4;
            3'd2:    return z ? p4 : tgt;
            3'd3,
            3'd4:    return (p4 & 32'hF000_0000) + {6'd0, idx} * 32'd4;
            3'd5:    return jr - (jr % 32'd4);
            default: return p4;
        endcase
    endfunction

    task automatic do_reset();
        rst_n      = 1'b0;
        imem_ready = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        step();
        step();
        check("rst_pc", pc, 32'h0000_3000);
        check("rst_instr", instr, 32'h0);
        check1("rst_valid", instr_valid, 1'b0);
        check1("rst_req", imem_req, 1'b0);
        check1("rst_pc_err", pc_err, 1'b0);
        rst_n = 1'b1;
        #1;
        check1("boot_req", imem_req, 1'b0);
        step();
        m_pc    = 32'h0000_3000;
        m_instr = 32'h0;
        check("boot_instr_ignored", instr, 32'h0);
    endtask

    // Enters at FETCH; leaves at EXEC with the fetched word in instr.
    task automatic do_fetch(input int delay);
        logic [31:0] word;
        word = $urandom;
        for (int k = 0; k < delay; k++) begin
            imem_ready = 1'b0;
            imem_rdata = $urandom;
            check1("fetch_req", imem_req, 1'b1);
            check("fetch_addr", imem_addr, m_pc);
            check("fetch_instr_hold", instr, m_instr);
            check1("fetch_valid", instr_valid, 1'b0);
            step();
        end
        imem_ready = 1'b1;
        imem_rdata = word;
        check1("fetch_req_rdy", imem_req, 1'b1);
        check("fetch_addr_rdy", imem_addr, m_pc);
        step();
        m_instr    = word;
        imem_ready = 1'($urandom);
        imem_rdata = $urandom;
        check1("exec_valid", instr_valid, 1'b1);
        check1("exec_req", imem_req, 1'b0);
        check("exec_instr", instr, m_instr);
        check1("exec_pc_err_low", pc_err, 1'b0);
    endtask

    // Enters at EXEC; leaves at FETCH after the commit edge.
    task automatic do_exec(input logic [2:0] op, input logic z, input logic [31:0] e,
                           input logic [25:0] idx, input logic [31:0] jr, input int stalls,
                           input logic [31:0] exp_npc, input logic exp_err);
        npc_op = op; zero = z; ext_imm = e; instr_index = idx; jr_target = jr;
        for (int s = 0; s < stalls; s++) begin
            stall      = 1'b1;
            imem_ready = 1'($urandom);
            imem_rdata = $urandom;
            check("stall_pc", pc, m_pc);
            check("stall_pc_plus4", pc_plus4, m_pc + 32'd4);
            step();
            check1("stall_valid", instr_valid, 1'b1);
            check("stall_instr", instr, m_instr);
            check1("stall_pc_err", pc_err, 1'b0);
        end
        stall = 1'b0;
        check("exec_pc", pc, m_pc);
        check("exec_pc_plus4", pc_plus4, m_pc + 32'd4);
        step();
        check("commit_npc", pc, exp_npc);
        check1("commit_pc_err", pc_err, exp_err);
        check1("commit_req", imem_req, 1'b1);
        check1("commit_valid", instr_valid, 1'b0);
        m_pc = exp_npc;
        npc_op = 3'($urandom); zero = 1'($urandom); ext_imm = $urandom;
        instr_index = 26'($urandom); jr_target = $urandom;
    endtask

    initial begin
        vt[0]  = '{NPC_SEQ, 1'b0, 32'h0,         26'h0,       32'h0,         0, 0, 32'h0000_3000, 32'h0000_3004, 1'b0};
        vt[1]  = '{NPC_SEQ, 1'b0, 32'h0,         26'h0,       32'h0,         0, 0, 32'h0000_3004, 32'h0000_3008, 1'b0};
        vt[2]  = '{NPC_BEQ, 1'b1, 32'hFFFF_FFFF, 26'h0,       32'h0,         3, 2, 32'h0000_3008, 32'h0000_3008, 1'b0};
        vt[3]  = '{NPC_BEQ, 1'b0, 32'hFFFF_FFFF, 26'h0,       32'h0,         0, 0, 32'h0000_3008, 32'h0000_300C, 1'b0};
        vt[4]  = '{NPC_J,   1'b0, 32'h0,         26'h0C00,    32'h0,         1, 0, 32'h0000_300C, 32'h0000_3000, 1'b0};
        vt[5]  = '{NPC_BNE, 1'b0, 32'h0000_0004, 26'h0,       32'h0,         0, 0, 32'h0000_3000, 32'h0000_3014, 1'b0};
        vt[6]  = '{NPC_BEQ, 1'b1, 32'hFFFF_FFFE, 26'h0,       32'h0,         0, 1, 32'h0000_3014, 32'h0000_3010, 1'b0};
        vt[7]  = '{NPC_JAL, 1'b0, 32'h0,         26'h0C40,    32'h0,         0, 0, 32'h0000_3010, 32'h0000_3100, 1'b0};
        vt[8]  = '{NPC_JR,  1'b0, 32'h0,         26'h0,       32'h0000_3023, 0, 0, 32'h0000_3100, 32'h0000_3020, 1'b1};
        vt[9]  = '{NPC_JR,  1'b0, 32'h0,         26'h0,       32'h0000_3020, 2, 0, 32'h0000_3020, 32'h0000_3020, 1'b0};
        vt[10] = '{NPC_BNE, 1'b1, 32'h0000_0005, 26'h0,       32'h0,         0, 0, 32'h0000_3020, 32'h0000_3024, 1'b0};
        vt[11] = '{3'b110,  1'b1, 32'h0000_0010, 26'h1,       32'h0,         0, 0, 32'h0000_3024, 32'h0000_3028, 1'b0};
        vt[12] = '{3'b111,  1'b1, 32'h0000_0008, 26'h2,       32'h0000_0001, 0, 0, 32'h0000_3028, 32'h0000_302C, 1'b0};
        vt[13] = '{NPC_JR,  1'b0, 32'h0,         26'h0,       32'hF000_0000, 0, 0, 32'h0000_302C, 32'hF000_0000, 1'b0};
        vt[14] = '{NPC_J,   1'b0, 32'h0,         26'h3FF_FFFF, 32'h0,        0, 0, 32'hF000_0000, 32'hFFFF_FFFC, 1'b0};
        vt[15] = '{NPC_SEQ, 1'b0, 32'h0,         26'h0,       32'h0,         0, 0, 32'hFFFF_FFFC, 32'h0000_0000, 1'b0};
        vt[16] = '{NPC_BEQ, 1'b1, 32'h3FFF_FFFF, 26'h0,       32'h0,         0, 0, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vt[17] = '{NPC_JR,  1'b0, 32'h0,         26'h0,       32'h0000_3001, 0, 0, 32'h0000_0000, 32'h0000_3000, 1'b1};

        do_reset();

        for (int i = 0; i < 18; i++) begin
            check("tbl_start_pc", pc, vt[i].exp_pc);
            do_fetch(vt[i].delay);
            if (vt[i].op == NPC_JAL)
                check("tbl_jal_link", pc_plus4, vt[i].exp_pc + 32'd4);
            do_exec(vt[i].op, vt[i].z, vt[i].ext, vt[i].idx, vt[i].jr, vt[i].stalls,
                    vt[i].exp_npc, vt[i].exp_err);
        end

        for (int n = 0; n < 150; n++) begin
            logic [2:0]  op;
            logic        z;
            logic [31:0] e;
            logic [25:0] idx;
            logic [31:0] jr;
            logic        err;
            op  = 3'($urandom_range(0, 7));
            z   = 1'($urandom);
            e   = ($urandom_range(0, 1) == 1) ? $urandom : 32'($signed(16'($urandom)));
            idx = 26'($urandom);
            jr  = $urandom;
            err = (op == 3'd5) && (jr % 32'd4 != 0);
            do_fetch($urandom_range(0, 2));
            do_exec(op, z, e, idx, jr, $urandom_range(0, 2), model_npc(m_pc, op, z, e, idx, jr), err);
        end

        // Move away from the reset vector, then reset asynchronously in the middle of a fetch.
        do_fetch(0);
        do_exec(NPC_JR, 1'b0, 32'h0, 26'h0, 32'h0000_4000, 0, 32'h0000_4000, 1'b0);
        imem_ready = 1'b0;
        step();
        step();
        check1("midfetch_req", imem_req, 1'b1);
        check("midfetch_addr", imem_addr, 32'h0000_4000);
        #3;
        rst_n      = 1'b0;
        imem_ready = 1'b1;
        imem_rdata = 32'hCAFE_F00D;
        #1;
        check("async_rst_pc", pc, 32'h0000_3000);
        check1("async_rst_req", imem_req, 1'b0);
        check1("async_rst_valid", instr_valid, 1'b0);
        step();
        check("late_ready_ignored", instr, 32'h0);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            do_fetch(0);
            do_exec(NPC_SEQ, 1'b0, 32'h0, 26'h0, 32'h0, 0, m_pc + 32'd4, 1'b0);
        end
        check("post_reset_seq_pc", pc, 32'h0000_300C);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
